// File: rtl/piece_gen_if.sv
// rtl/piece_gen_if.sv - button/mode inputs and piece-queue outputs of the next-piece generator
interface piece_gen_if #(
    parameter int PIECE_W       = 3,
    parameter int PREVIEW_DEPTH = 3,
    parameter int CNT_W         = 8
);
    logic                             button_i;
    logic                             hold_i;
    logic                             mode_i;
    logic [PIECE_W-1:0]               piece_o;
    logic [PREVIEW_DEPTH*PIECE_W-1:0] preview_o;
    logic                             valid_o;
    logic [PIECE_W-1:0]               held_o;
    logic                             held_valid_o;
    logic [1:0]                       current_state_o;
    logic [CNT_W-1:0]                 count_o;

    modport master (
        output button_i, hold_i, mode_i,
        input  piece_o, preview_o, valid_o, held_o, held_valid_o, current_state_o, count_o
    );

    modport slave (
        input  button_i, hold_i, mode_i,
        output piece_o, preview_o, valid_o, held_o, held_valid_o, current_state_o, count_o
    );
endinterface

// File: rtl/piece_gen.sv
// rtl/piece_gen.sv - next-piece generator with lookahead queue, 7-bag mode and hold slot
module piece_gen #(
    parameter int          NUM_PIECES    = 7,
    parameter int          PIECE_W       = 3,
    parameter int          PREVIEW_DEPTH = 3,
    parameter int          CNT_W         = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic        clk,
    input logic        rst_i,
    piece_gen_if.slave bus
);
    localparam int QN = PREVIEW_DEPTH + 1;
    localparam int FW = $clog2(QN);

    typedef enum logic [1:0] {
        S_FILL   = 2'b00,
        S_READY  = 2'b01,
        S_LOCKED = 2'b10
    } state_t;

    state_t                 state, state_next;
    logic [PIECE_W-1:0]     q [QN];
    logic [FW-1:0]          fill_idx;
    logic [15:0]            lfsr;
    logic [2:0]             btn_sync, hld_sync;
    logic                   req_p, hold_p;
    logic                   mode_r, pending, valid, held_valid;
    logic [PIECE_W-1:0]     held, last_gen, gen_code, idx;
    logic [NUM_PIECES-1:0]  mask, mask_upd;
    logic [CNT_W-1:0]       count;
    logic                   found;
    int                     cand;
    logic                   do_fill, do_shift, do_store, do_swap, count_inc;
    logic [PREVIEW_DEPTH*PIECE_W-1:0] preview;

    // [0]/[1] are the two synchroniser flops, [2] remembers the previous synchronised level
    assign req_p  = btn_sync[1] & ~btn_sync[2];
    assign hold_p = hld_sync[1] & ~hld_sync[2];

    // Bag mode walks upward from the LFSR candidate to the first code not yet dealt this bag
    always_comb begin
        gen_code = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        if (mode_r) begin
            cand = int'(lfsr[7:0]) % NUM_PIECES;
            for (int k = 0; k < NUM_PIECES; k++) begin
                idx = PIECE_W'((cand + k) % NUM_PIECES);
                if (!found && !mask[idx]) begin
                    gen_code = idx;
                    found    = 1'b1;
                end
            end
        end else if (int'(last_gen) == NUM_PIECES - 1) begin
            gen_code = '0;
        end else begin
            gen_code = last_gen + 1'b1;
        end
        mask_upd = mask | (NUM_PIECES'(1) << gen_code);
        if (&mask_upd)
            mask_upd = '0;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) state <= S_FILL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_fill    = 1'b0;
        do_shift   = 1'b0;
        do_store   = 1'b0;
        do_swap    = 1'b0;
        count_inc  = 1'b0;
        case (state)
            S_FILL: begin
                do_fill = 1'b1;
                if (fill_idx == FW'(PREVIEW_DEPTH))
                    state_next = S_READY;
            end
            S_READY: begin
                if (req_p || pending) begin
                    do_shift  = 1'b1;
                    count_inc = 1'b1;
                end else if (hold_p) begin
                    if (held_valid) begin
                        do_swap = 1'b1;
                    end else begin
                        do_store = 1'b1;
                        do_shift = 1'b1;
                    end
                    state_next = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (req_p) begin
                    do_shift   = 1'b1;
                    count_inc  = 1'b1;
                    state_next = S_READY;
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < QN; i++)
                q[i] <= '0;
            fill_idx   <= '0;
            lfsr       <= LFSR_SEED;
            btn_sync   <= '0;
            hld_sync   <= '0;
            mode_r     <= 1'b0;
            pending    <= 1'b0;
            valid      <= 1'b0;
            held       <= '0;
            held_valid <= 1'b0;
            last_gen   <= PIECE_W'(NUM_PIECES - 1);
            mask       <= '0;
            count      <= '0;
        end else begin
            lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            btn_sync <= {btn_sync[1:0], bus.button_i};
            hld_sync <= {hld_sync[1:0], bus.hold_i};
            mode_r   <= bus.mode_i;

            if (do_fill || do_shift) begin
                last_gen <= gen_code;
                if (mode_r)
                    mask <= mask_upd;
            end
            // A mode change starts a fresh bag regardless of any push this edge
            if (bus.mode_i != mode_r)
                mask <= '0;

            if (state == S_FILL && req_p)
                pending <= 1'b1;
            else if (do_shift)
                pending <= 1'b0;

            if (do_fill) begin
                q[fill_idx] <= gen_code;
                if (fill_idx == FW'(PREVIEW_DEPTH)) begin
                    fill_idx <= '0;
                    valid    <= 1'b1;
                end else begin
                    fill_idx <= fill_idx + 1'b1;
                end
            end

            if (do_shift) begin
                for (int i = 0; i < PREVIEW_DEPTH; i++)
                    q[i] <= q[i+1];
                q[PREVIEW_DEPTH] <= gen_code;
            end

            if (do_store) begin
                held       <= q[0];
                held_valid <= 1'b1;
            end

            if (do_swap) begin
                q[0] <= held;
                held <= q[0];
            end

            if (count_inc)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        preview = '0;
        for (int i = 0; i < PREVIEW_DEPTH; i++)
            preview[i*PIECE_W +: PIECE_W] = q[i+1];
    end

    assign bus.piece_o         = q[0];
    assign bus.preview_o       = preview;
    assign bus.valid_o         = valid;
    assign bus.held_o          = held;
    assign bus.held_valid_o    = held_valid;
    assign bus.current_state_o = state;
    assign bus.count_o         = count;
endmodule

// File: tb/tb_piece_gen.sv
// tb/tb_piece_gen.sv - self-checking bench for piece_gen against a queue-level reference model
module tb_piece_gen;
    localparam int NP = 7;
    localparam int PW = 3;
    localparam int D  = 3;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    piece_gen_if #(.PIECE_W(PW), .PREVIEW_DEPTH(D), .CNT_W(CW)) bus ();

    piece_gen #(
        .NUM_PIECES(NP), .PIECE_W(PW), .PREVIEW_DEPTH(D), .CNT_W(CW), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst_i(rst_i),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: the queue as a list of codes, plus the hold slot and game state
    int mq[$];
    int mlast, mcount, mheld, mheld_v, mstate;
    int codes[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_push();
        mlast = (mlast + 1) % NP;
        mq.push_back(mlast);
    endtask

    task automatic m_reset_fill();
        mq.delete();
        mlast = NP - 1;
        for (int i = 0; i <= D; i++) m_push();
        mcount = 0; mheld = 0; mheld_v = 0; mstate = 1;
    endtask

    task automatic m_request();
        void'(mq.pop_front());
        m_push();
        mcount = (mcount + 1) % (1 << CW);
        mstate = 1;
    endtask

    task automatic m_hold();
        int t;
        if (mstate == 1) begin
            if (mheld_v == 0) begin
                mheld = mq[0];
                mheld_v = 1;
                void'(mq.pop_front());
                m_push();
            end else begin
                t = mq[0]; mq[0] = mheld; mheld = t;
            end
            mstate = 2;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_piece"}, bus.piece_o, mq[0]);
        for (int i = 1; i <= D; i++)
            chk($sformatf("%s_prev%0d", tag, i), bus.preview_o[(i-1)*PW +: PW], mq[i]);
        chk({tag, "_count"}, bus.count_o, mcount);
        chk({tag, "_held"}, bus.held_o, mheld);
        chk({tag, "_heldv"}, bus.held_valid_o, mheld_v);
        chk({tag, "_state"}, bus.current_state_o, mstate);
        chk({tag, "_valid"}, bus.valid_o, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_piece"}, bus.piece_o, 0);
        chk({tag, "_preview"}, bus.preview_o, 0);
        chk({tag, "_valid"}, bus.valid_o, 0);
        chk({tag, "_held"}, bus.held_o, 0);
        chk({tag, "_heldv"}, bus.held_valid_o, 0);
        chk({tag, "_state"}, bus.current_state_o, 0);
        chk({tag, "_count"}, bus.count_o, 0);
    endtask

    task automatic press(input int len, input bit b, input bit h);
        bus.button_i = b;
        bus.hold_i   = h;
        cyc(len);
        bus.button_i = 1'b0;
        bus.hold_i   = 1'b0;
        cyc(4);
    endtask

    // Reset, release on a falling edge, then check the FILL timeline edge by edge
    task automatic reset_and_fill(input string tag);
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
        cyc(3);
        chk({tag, "_valid_e3"}, bus.valid_o, 0);
        chk({tag, "_state_e3"}, bus.current_state_o, 0);
        cyc(1);
        m_reset_fill();
        compare_all(tag);
    endtask

    initial begin
        int seen;
        bus.button_i = 1'b0;
        bus.hold_i   = 1'b0;
        bus.mode_i   = 1'b0;
        #1;
        check_zero("por");

        reset_and_fill("fill");

        // Exact latency: the press lands on the third rising edge
        bus.button_i = 1'b1;
        cyc(2);
        chk("lat_e2_count", bus.count_o, 0);
        cyc(1);
        chk("lat_e3_count", bus.count_o, 1);
        bus.button_i = 1'b0;
        cyc(3);
        m_request();
        compare_all("lat");

        // Sequential run: six more presses of random length, one held for 50 cycles
        for (int i = 0; i < 6; i++) begin
            press((i == 3) ? 50 : int'($urandom_range(1, 8)), 1'b1, 1'b0);
            m_request();
            compare_all($sformatf("seq%0d", i));
        end
        chk("seq_piece_wrap", bus.piece_o, 0);
        chk("seq_count7", bus.count_o, 7);

        // 256 back-to-back presses bring the counter round to the same value
        for (int i = 0; i < 256; i++) begin
            bus.button_i = 1'b1;
            cyc(1);
            bus.button_i = 1'b0;
            cyc(1);
            m_request();
        end
        cyc(4);
        compare_all("wrap");
        chk("wrap_count", bus.count_o, 7);

        // Random interleaving of requests, holds and simultaneous presses
        for (int i = 0; i < 24; i++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                press($urandom_range(1, 6), 1'b1, 1'b0);
                m_request();
            end else if (op == 1) begin
                press($urandom_range(1, 6), 1'b0, 1'b1);
                m_hold();
            end else begin
                press(1, 1'b1, 1'b1);
                m_request();
            end
            compare_all($sformatf("rnd%0d", i));
        end

        // Hold slot walk-through from piece 1
        reset_and_fill("t4fill");
        press(2, 1'b1, 1'b0); m_request();
        chk("t4_start_piece", bus.piece_o, 1);
        press(2, 1'b0, 1'b1); m_hold();
        chk("t4_store_held", bus.held_o, 1);
        chk("t4_store_piece", bus.piece_o, 2);
        chk("t4_store_state", bus.current_state_o, 2);
        compare_all("t4_store");
        press(2, 1'b0, 1'b1); m_hold();
        compare_all("t4_ignored");
        press(2, 1'b1, 1'b0); m_request();
        chk("t4_ready_state", bus.current_state_o, 1);
        press(2, 1'b0, 1'b1); m_hold();
        chk("t4_swap_piece", bus.piece_o, 1);
        chk("t4_swap_held", bus.held_o, 3);
        compare_all("t4_swap");

        // Press during FILL is kept pending and serviced on the first READY edge
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
        bus.button_i = 1'b1;
        cyc(1);
        bus.button_i = 1'b0;
        cyc(3);
        chk("t5_fill_count", bus.count_o, 0);
        chk("t5_fill_state", bus.current_state_o, 1);
        cyc(1);
        m_reset_fill();
        m_request();
        compare_all("t5_pending");
        press(1, 1'b1, 1'b1); m_request();
        chk("t5_both_heldv", bus.held_valid_o, 0);
        compare_all("t5_both");

        // Asynchronous reset while LOCKED with five pieces consumed
        reset_and_fill("t6fill");
        for (int i = 0; i < 5; i++) begin
            press($urandom_range(1, 3), 1'b1, 1'b0);
            m_request();
        end
        press(1, 1'b0, 1'b1); m_hold();
        chk("t6_locked_count", bus.count_o, 5);
        chk("t6_locked_state", bus.current_state_o, 2);
        rst_i = 1'b1;
        #1;
        check_zero("t6_async");
        reset_and_fill("t6refill");

        // Bag mode: every aligned group of seven dealt codes is a permutation
        bus.mode_i = 1'b1;
        cyc(3);
        codes.delete();
        for (int i = 0; i < 21; i++) begin
            press($urandom_range(1, 4), 1'b1, 1'b0);
            codes.push_back(int'(bus.preview_o[D*PW-1 -: PW]));
        end
        chk("bag_count", bus.count_o, 21);
        for (int g = 0; g < 3; g++) begin
            seen = 0;
            for (int k = 0; k < NP; k++) begin
                chk($sformatf("bag_range_%0d_%0d", g, k), codes[g*NP+k] < NP, 1);
                seen = seen | (1 << (codes[g*NP+k] % 8));
            end
            chk($sformatf("bag_perm_%0d", g), seen, 32'h7F);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
